clkdiv_prog_phi2: RTL
=====================

Name: clkdiv_prog_phi2

Overview:
Programmable, glitch-free CPU clock generator driven from the single fast clock hsclk_in. It generalises the fixed /1, /2 and /4 selection to any half-period of 1..2^DIV_W-1 hsclk cycles. Ratio changes are applied only at the PHI2 falling edge, and a hold (stretch) handshake can freeze clkout in the PHI2 (high) state. It sits between the board oscillator and the CPU clock input, and is controlled by the mode/speed register logic.

Parameters:
DIV_W, 4, width of half-period field; legal half-period 1..2^DIV_W-1
RESET_HALF, 2, half-period loaded at reset (must be 1..2^DIV_W-1)

Ports:
hsclk_in  input  1  fast source clock; all state changes on posedge
rst_b  input  1  asynchronous active-low reset
div_req  input  1  one-cycle request to change ratio, value on div_half
div_half  input  DIV_W  requested half-period in hsclk cycles; 0 coerced to 1
div_ack  output  1  one-cycle pulse: new ratio applied at this falling edge
div_pend  output  1  a request is captured but not yet applied
div_cur  output  DIV_W  half-period currently in force
hold_req  input  1  level request to stretch the PHI2-high phase
hold_ack  output  1  high while clkout is frozen high by hold
clkout  output  1  registered CPU clock (PHI2 = high)
rise_stb  output  1  one-cycle pulse coincident with clkout 0->1
fall_stb  output  1  one-cycle pulse coincident with clkout 1->0

Behaviour:
- Reset (async, rst_b=0): clkout=0, state RUN_LO, cnt=RESET_HALF-1, div_cur=RESET_HALF, div_pend=0, div_ack=0, hold_ack=0, rise_stb=0, fall_stb=0.
- States: RUN_LO, RUN_HI, HOLD_HI. cnt is DIV_W bits, decrements by one per cycle while nonzero in RUN_LO/RUN_HI.
- RUN_LO, cnt==0: clkout<=1, rise_stb<=1, cnt<=div_cur-1, go to RUN_HI.
- RUN_HI, cnt==0:
  - If hold_req=1: go to HOLD_HI, hold_ack<=1, clkout stays 1.
  - Else do a fall: clkout<=0, fall_stb<=1, go to RUN_LO.
- HOLD_HI: while hold_req=1, stay with no change. On the first cycle with hold_req=0: fall, hold_ack<=0.
- Fall reload: eff = div_req ? div_half : pend_val (0 coerced to 1).
  - If div_req or div_pend: div_cur<=eff, cnt<=eff-1, div_ack<=1, div_pend<=0.
  - Else: cnt<=div_cur-1.
- Period with no hold: exactly 2*div_cur hsclk cycles, 50% duty. High phase lasts at least div_cur cycles, plus one cycle per hold cycle.
- Request capture:
  - div_req outside a fall cycle sets div_pend=1 and pend_val=div_half.
  - A second div_req before application overwrites pend_val (last wins); only one div_ack is produced.
  - div_req in the fall cycle bypasses pend_val, applies directly, and leaves div_pend=0.
- No clkout pulse is ever shorter than min(old,new) half-period. The ratio never changes mid-phase.
- hold_req asserted in RUN_LO, or dropped before cnt reaches 0 in RUN_HI, has no effect. hold is sampled only at the end of the high phase and in HOLD_HI.
- Strobes and div_ack are single-cycle and registered, and align with the clkout edge they describe.
- Reset mid-phase or mid-hold immediately forces the reset values; any pending request is discarded.

Decomposition:
- Package clkdiv_pkg: state enum {RUN_LO, RUN_HI, HOLD_HI}, DIV_W default, and the function coerce_half (0 maps to 1).
- One natural sub-module: clkdiv_req_hold. It holds the pend_val/div_pend capture register with last-wins and bypass selection, and outputs eff.
- Counter and FSM stay in the top module.

Test Plan:
- Reset release with RESET_HALF=2 -> clkout low 2 cycles, high 2 cycles, repeating with period 4. rise_stb/fall_stb align with the edges; div_cur=2.
- div_req with div_half=1 mid-high phase -> div_pend=1 until the next fall, then div_ack pulse and div_pend=0. Following periods are 2 cycles; the current high phase still completes 2 cycles.
- div_req=5 then div_req=3 in the same low phase -> one div_ack at the next fall, div_cur=3, period 6. Also div_req=0 -> div_cur=1.
- hold_req=1 held from mid-high for 7 cycles past phase end -> hold_ack high 7 cycles and clkout high div_cur+7 cycles. Fall occurs on the cycle after hold_req drops.
- Pulse hold_req only during RUN_LO, or drop it before the high phase ends -> no hold_ack and period unchanged.
- Assert rst_b=0 during HOLD_HI with a pending request -> clkout, hold_ack and div_pend go 0 immediately. After release, div_cur=RESET_HALF and no div_ack occurs.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared state encoding and half-period coercion for the PHI2 clock divider
package clkdiv_pkg;
    localparam int DIV_W_DEF = 4;
    typedef enum logic [1:0] {RUN_LO, RUN_HI, HOLD_HI} state_e;
    function automatic logic [31:0] coerce_half(input logic [31:0] h);
        return (h == '0) ? 32'd1 : h;
    endfunction
endpackage

// File: rtl/clkdiv_req_hold.sv
// clkdiv_req_hold: captures ratio requests (last wins) and selects the value applied at the next fall
module clkdiv_req_hold
    import clkdiv_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             hsclk_in,
    input  logic             rst_b,
    input  logic             div_req,
    input  logic [DIV_W-1:0] div_half,
    input  logic             fall,
    output logic             div_pend,
    output logic             apply,
    output logic [DIV_W-1:0] eff
);
    logic             pend_q, pend_d;
    logic [DIV_W-1:0] val_q, val_d;
    always_comb begin
        pend_d = fall ? 1'b0 : (div_req | pend_q);
        val_d  = (div_req && !fall) ? div_half : val_q;
    end
    always_ff @(posedge hsclk_in or negedge rst_b) begin
        if (!rst_b) begin
            pend_q <= 1'b0;
            val_q  <= '0;
        end else begin
            pend_q <= pend_d;
            val_q  <= val_d;
        end
    end
    // a request arriving in the fall cycle bypasses the capture register
    assign apply    = div_req | pend_q;
    assign eff      = DIV_W'(coerce_half(32'(div_req ? div_half : val_q)));
    assign div_pend = pend_q;
endmodule

// File: rtl/clkdiv_prog_phi2.sv
// clkdiv_prog_phi2: programmable glitch-free PHI2 clock with fall-aligned ratio change and high-phase hold
module clkdiv_prog_phi2
    import clkdiv_pkg::*;
#(
    parameter int DIV_W      = DIV_W_DEF,
    parameter int RESET_HALF = 2
) (
    input  logic             hsclk_in,
    input  logic             rst_b,
    input  logic             div_req,
    input  logic [DIV_W-1:0] div_half,
    output logic             div_ack,
    output logic             div_pend,
    output logic [DIV_W-1:0] div_cur,
    input  logic             hold_req,
    output logic             hold_ack,
    output logic             clkout,
    output logic             rise_stb,
    output logic             fall_stb
);
    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);
    state_e           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d, div_cur_q, div_cur_d, eff;
    logic             clkout_q, clkout_d, rise_q, rise_d, fall_q, fall_d;
    logic             ack_q, ack_d, hold_ack_q, hold_ack_d, do_fall, apply;
    clkdiv_req_hold #(.DIV_W(DIV_W)) u_req (
        .hsclk_in (hsclk_in),
        .rst_b    (rst_b),
        .div_req  (div_req),
        .div_half (div_half),
        .fall     (do_fall),
        .div_pend (div_pend),
        .apply    (apply),
        .eff      (eff)
    );
    always_comb begin
        state_d    = state_q;
        cnt_d      = (cnt_q != '0 && state_q != HOLD_HI) ? cnt_q - ONE : cnt_q;
        clkout_d   = clkout_q;
        hold_ack_d = hold_ack_q;
        div_cur_d  = div_cur_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        ack_d      = 1'b0;
        do_fall    = 1'b0;
        case (state_q)
            RUN_LO: if (cnt_q == '0) begin
                clkout_d = 1'b1;
                rise_d   = 1'b1;
                cnt_d    = div_cur_q - ONE;
                state_d  = RUN_HI;
            end
            RUN_HI: if (cnt_q == '0) begin
                if (hold_req) begin
                    state_d    = HOLD_HI;
                    hold_ack_d = 1'b1;
                end else begin
                    do_fall = 1'b1;
                end
            end
            HOLD_HI: do_fall = !hold_req;
            default: state_d = RUN_LO;
        endcase
        // the ratio only ever changes here, so no phase is cut short
        if (do_fall) begin
            clkout_d   = 1'b0;
            fall_d     = 1'b1;
            hold_ack_d = 1'b0;
            state_d    = RUN_LO;
            div_cur_d  = apply ? eff : div_cur_q;
            cnt_d      = (apply ? eff : div_cur_q) - ONE;
            ack_d      = apply;
        end
    end
    always_ff @(posedge hsclk_in or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= RUN_LO;
            cnt_q      <= DIV_W'(RESET_HALF - 1);
            div_cur_q  <= DIV_W'(RESET_HALF);
            clkout_q   <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            ack_q      <= 1'b0;
            hold_ack_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_cur_q  <= div_cur_d;
            clkout_q   <= clkout_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            ack_q      <= ack_d;
            hold_ack_q <= hold_ack_d;
        end
    end
    assign clkout   = clkout_q;
    assign rise_stb = rise_q;
    assign fall_stb = fall_q;
    assign div_ack  = ack_q;
    assign hold_ack = hold_ack_q;
    assign div_cur  = div_cur_q;
endmodule
